// File: rtl/m81_pkg.sv
//------------------------------------------------------------------------------
// Module : m81_pkg
// Brief  : Shared constants and select type for the m81 8-to-1 selector.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package m81_pkg;
   localparam int N_IN  = 8;
   localparam int SEL_W = 3;

   typedef logic [SEL_W-1:0] sel_t;
endpackage

`default_nettype wire

// File: rtl/m81_edge_det.sv
//------------------------------------------------------------------------------
// Module : m81_edge_det
// Brief  : 1-bit rise/fall detector; pulses are combinational from the input
//          and its registered previous value.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module m81_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_rise,
   output logic o_fall
);

   logic r_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev <= 1'b0;
      end else begin
         r_prev <= i_d;
      end
   end

   assign o_rise = i_d & ~r_prev;
   assign o_fall = ~i_d & r_prev;

endmodule

`default_nettype wire

// File: rtl/m81_mux8.sv
//------------------------------------------------------------------------------
// Module : m81_mux8
// Brief  : 8-to-1 lane selector with combinational and registered outputs.
//          Define M81_EDGE_DET_EN to add out_rise/out_fall on out_q[0].
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module m81_mux8
   import m81_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] D0,
   input  logic [WIDTH-1:0] D1,
   input  logic [WIDTH-1:0] D2,
   input  logic [WIDTH-1:0] D3,
   input  logic [WIDTH-1:0] D4,
   input  logic [WIDTH-1:0] D5,
   input  logic [WIDTH-1:0] D6,
   input  logic [WIDTH-1:0] D7,
   input  logic             S0,
   input  logic             S1,
   input  logic             S2,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_q,
`ifdef M81_EDGE_DET_EN
   output logic             out_rise,
   output logic             out_fall,
`endif
   output sel_t             sel_q
);

   sel_t             w_sel;
   logic [WIDTH-1:0] w_out;
   logic [WIDTH-1:0] r_out_q;
   sel_t             r_sel_q;

   assign w_sel = {S2, S1, S0};

   // All eight codes are legal, so the case is full without a default item.
   always_comb begin
      w_out = '0;
      case (w_sel)
         3'd0: w_out = D0;
         3'd1: w_out = D1;
         3'd2: w_out = D2;
         3'd3: w_out = D3;
         3'd4: w_out = D4;
         3'd5: w_out = D5;
         3'd6: w_out = D6;
         3'd7: w_out = D7;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_q <= '0;
         r_sel_q <= '0;
      end else begin
         r_out_q <= w_out;
         r_sel_q <= w_sel;
      end
   end

   assign out   = w_out;
   assign out_q = r_out_q;
   assign sel_q = r_sel_q;

`ifdef M81_EDGE_DET_EN
   m81_edge_det u_edge_det (
      .clk    (clk),
      .rst    (rst),
      .i_d    (r_out_q[0]),
      .o_rise (out_rise),
      .o_fall (out_fall)
   );
`endif

endmodule

`default_nettype wire

// File: tb/tb_m81_mux8.sv
//------------------------------------------------------------------------------
// Module : tb_m81_mux8
// Brief  : Self-checking bench for m81_mux8 against a lane-array reference.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_m81_mux8;

   localparam int W = 3;

   logic         clk;
   logic         rst;
   logic [W-1:0] d [8];
   logic [2:0]   s;
   logic [W-1:0] out;
   logic [W-1:0] out_q;
   logic [2:0]   sel_q;
`ifdef M81_EDGE_DET_EN
   logic         out_rise;
   logic         out_fall;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   m81_mux8 #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .D0    (d[0]),
      .D1    (d[1]),
      .D2    (d[2]),
      .D3    (d[3]),
      .D4    (d[4]),
      .D5    (d[5]),
      .D6    (d[6]),
      .D7    (d[7]),
      .S0    (s[0]),
      .S1    (s[1]),
      .S2    (s[2]),
      .out   (out),
      .out_q (out_q),
`ifdef M81_EDGE_DET_EN
      .out_rise (out_rise),
      .out_fall (out_fall),
`endif
      .sel_q (sel_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: the selected lane is simply the array element addressed by sel.
   function automatic logic [W-1:0] ref_out();
      return d[s];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_d();
      for (int i = 0; i < 8; i++) d[i] = '0;
   endtask

   logic [W-1:0] exp_q;
   logic [2:0]   exp_sel;
   logic         prev_q0;
   logic         new_prev;

   initial begin
      rst = 1'b1;
      s   = 3'd0;
      clear_d();
      prev_q0  = 1'b0;
      new_prev = 1'b0;

      // Reset state
      step();
      step();
      chk("reset_out_q", 32'(out_q), 32'd0);
      chk("reset_sel_q", 32'(sel_q), 32'd0);
`ifdef M81_EDGE_DET_EN
      chk("reset_rise", 32'(out_rise), 32'd0);
      chk("reset_fall", 32'(out_fall), 32'd0);
`endif
      rst = 1'b0;

      // Exhaustive select sweep with D_i = i
      for (int i = 0; i < 8; i++) d[i] = W'(i);
      for (int k = 0; k < 8; k++) begin
         s = 3'(k);
         #1;
         chk("sweep_out", 32'(out), 32'(k));
         step();
         chk("sweep_out_q", 32'(out_q), 32'(k));
         chk("sweep_sel_q", 32'(sel_q), 32'(k));
      end

      // Reset held for two cycles: registered outputs clear, out still follows D3
      clear_d();
      d[3] = W'(1);
      s    = 3'd3;
      rst  = 1'b1;
      for (int k = 0; k < 2; k++) begin
         step();
         chk("rst_hold_out_q", 32'(out_q), 32'd0);
         chk("rst_hold_sel_q", 32'(sel_q), 32'd0);
         chk("rst_hold_out", 32'(out), 32'd1);
      end
      rst = 1'b0;
      step();
      chk("rst_release_out_q", 32'(out_q), 32'd1);
      chk("rst_release_sel_q", 32'(sel_q), 32'd3);

      // Reset pulse mid-stream: out_q 1,0,1
      step();
      chk("mid_rst_q0", 32'(out_q), 32'd1);
      rst = 1'b1;
      step();
      chk("mid_rst_q1", 32'(out_q), 32'd0);
      rst = 1'b0;
      step();
      chk("mid_rst_q2", 32'(out_q), 32'd1);

      // Simultaneous select and data change
      clear_d();
      s = 3'd2;
      step();
      chk("simul_pre_out_q", 32'(out_q), 32'd0);
      s    = 3'd5;
      d[5] = W'(1);
      #1;
      chk("simul_out", 32'(out), 32'd1);
      step();
      chk("simul_out_q", 32'(out_q), 32'd1);
      chk("simul_sel_q", 32'(sel_q), 32'd5);

`ifdef M81_EDGE_DET_EN
      // out_q[0] sequence 0,1,1,0 through lane 0
      clear_d();
      s   = 3'd0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("edge_rise_0", 32'(out_rise), 32'd0);
      chk("edge_fall_0", 32'(out_fall), 32'd0);
      d[0] = W'(1);
      step();
      chk("edge_rise_1", 32'(out_rise), 32'd1);
      chk("edge_fall_1", 32'(out_fall), 32'd0);
      step();
      chk("edge_rise_2", 32'(out_rise), 32'd0);
      chk("edge_fall_2", 32'(out_fall), 32'd0);
      d[0] = W'(0);
      step();
      chk("edge_rise_3", 32'(out_rise), 32'd0);
      chk("edge_fall_3", 32'(out_fall), 32'd1);
`endif

      // Toggling inputs: D_i half-period i+1 ns, S0/S1/S2 half-periods 9/10/11 ns
      for (int t = 0; t < 500; t++) begin
         for (int i = 0; i < 8; i++) d[i] = (((t / (i + 1)) % 2) != 0) ? W'(i + 1) : W'(7 - i);
         for (int j = 0; j < 3; j++) s[j] = (((t / (9 + j)) % 2) != 0);
         #0.5;
         chk("toggle_out", 32'(out), 32'(ref_out()));
         #0.5;
      end

      // Randomized traffic with occasional resets
      @(negedge clk);
      prev_q0 = out_q[0];
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         for (int i = 0; i < 8; i++) d[i] = W'($urandom);
         s   = 3'($urandom);
         rst = ($urandom_range(0, 9) == 0);
         #1;
         chk("rand_out", 32'(out), 32'(ref_out()));
         exp_q    = rst ? '0 : ref_out();
         exp_sel  = rst ? 3'd0 : s;
         new_prev = rst ? 1'b0 : prev_q0;
         @(posedge clk);
         #1;
         chk("rand_out_q", 32'(out_q), 32'(exp_q));
         chk("rand_sel_q", 32'(sel_q), 32'(exp_sel));
`ifdef M81_EDGE_DET_EN
         chk("rand_rise", 32'(out_rise), 32'(exp_q[0] & ~new_prev));
         chk("rand_fall", 32'(out_fall), 32'(~exp_q[0] & new_prev));
`endif
         prev_q0 = exp_q[0];
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
